divider16by8_seq: RTL and testbench

Sequential unsigned restoring divider: the inverse of the 8×8 multiplier datapath. It takes a 16-bit dividend, such as a product from the multiplier family, and an 8-bit divisor, and returns quotient and remainder. Each operation is resolved with one quotient bit per clock. The block sits beside the multiplier instances in the evaluation harness, where it reconstructs operands from products for error analysis.

---
 rtl/divider16by8_seq.sv | 172 +++++++++++++++++
 tb/tb_divider16by8_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/divider16by8_seq.sv
// divider16by8_seq
//   Sequential unsigned restoring divider. It takes a DW-bit dividend and a
//   VW-bit divisor and produces the quotient and remainder at one quotient
//   bit per clock, MSB first. A zero divisor returns immediately with
//   quotient = all ones, remainder = dividend[VW-1:0] and div_by_zero = 1.
//
//   Optional feature macro: DIV_RECHECK_EN
//     Defined:   after the last iteration, one extra registered cycle
//                rebuilds quotient*divisor + remainder and flags check_err
//                when the result differs from the latched dividend.
//     Undefined: there is no recheck logic and check_err is tied to 0.
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous, active-high reset
//     in_valid     dividend/divisor present
//     in_ready     block can accept an operation (decoded from state and rst)
//     dividend     unsigned dividend, DW bits
//     divisor      unsigned divisor, VW bits
//     out_valid    result present (registered)
//     out_ready    consumer accepts the result
//     quotient     unsigned quotient, DW bits
//     remainder    unsigned remainder, VW bits
//     div_by_zero  the divisor was zero
//     check_err    recheck mismatch (DIV_RECHECK_EN only, otherwise 0)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a new operation
//   BUSY  | one restoring iteration per cycle, cnt = 0..DW-1
//   CHECK | rebuild quotient*divisor + remainder (DIV_RECHECK_EN only)
//   DONE  | result held on the outputs until out_ready
module divider16by8_seq #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero,
    output logic          check_err
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

`ifdef DIV_RECHECK_EN
    typedef enum logic [1:0] {IDLE, BUSY, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

    state_t        state;
    logic [DW-1:0] dvd_sh;      // dividend, shifted left so the next bit is the MSB
    logic [VW-1:0] dvs_lat;
    logic [CW-1:0] cnt;

    // The partial remainder lives in the remainder register. After each
    // restore it is below the divisor, so VW bits hold it; the shifted trial
    // value needs VW+1 bits.
    logic [VW:0]   prem_shift;
    logic          q_bit;
    logic [VW-1:0] rem_next;

    assign in_ready = (state == IDLE) && !rst;

    // When the shifted value is at least the divisor, the difference is below
    // the divisor and therefore fits in VW bits, so the subtraction can be
    // done at VW bits without losing information.
    always_comb begin
        prem_shift = {remainder, dvd_sh[DW-1]};
        q_bit      = (prem_shift >= {1'b0, dvs_lat});
        rem_next   = prem_shift[VW-1:0];
        if (q_bit) begin
            rem_next = prem_shift[VW-1:0] - dvs_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dvd_sh      <= '0;
            dvs_lat     <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_sh  <= dividend;
                        dvs_lat <= divisor;
                        cnt     <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[VW-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                            state       <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    dvd_sh    <= {dvd_sh[DW-2:0], 1'b0};
                    remainder <= rem_next;
                    quotient  <= {quotient[DW-2:0], q_bit};
                    cnt       <= cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
`ifdef DIV_RECHECK_EN
                        state     <= CHECK;
`else
                        out_valid <= 1'b1;
                        state     <= DONE;
`endif
                    end
                end
`ifdef DIV_RECHECK_EN
                CHECK: begin
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DIV_RECHECK_EN
    logic [DW-1:0]    dvd_lat;
    logic [DW+VW-1:0] recon;

    // Exact reconstruction at full product width, so no carry is lost.
    always_comb begin
        recon = {{VW{1'b0}}, quotient} * {{DW{1'b0}}, dvs_lat}
              + {{DW{1'b0}}, remainder};
    end

    // Zero-divisor results never pass through CHECK, so check_err stays at
    // the 0 written at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_lat   <= '0;
            check_err <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            dvd_lat   <= dividend;
            check_err <= 1'b0;
        end else if (state == CHECK) begin
            check_err <= (recon != {{VW{1'b0}}, dvd_lat});
        end
    end
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_divider16by8_seq.sv
module tb_divider16by8_seq;

`ifdef DIV_RECHECK_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        check_err;

    divider16by8_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .check_err   (check_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rdy_auto = 1'b0;

    task automatic chk(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: plain integer division of the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'h00) begin
            e.q   = 16'hFFFF;
            e.r   = a[7:0];
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = 8'(a % b);
            e.dbz = 1'b0;
        end
        e.acc = 0;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        exp_t e;
        int   n = 0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 1'b0, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e     = model(a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(input int lim);
        int n = 0;
        while (!out_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", out_valid === 1'b1, 32'(out_valid), 32'd1);
    endtask

    task automatic wait_drain(input int lim);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size() == 0 && out_valid === 1'b0, 32'(sb.size()), 32'd0);
    endtask

    initial forever begin
        @(negedge clk);
        if (rdy_auto) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops on each new result, rechecks the held values at handshake.
    initial begin
        bit   prev_ov;
        bit   have;
        exp_t cur;
        int   lat;
        prev_ov = 1'b0;
        have    = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_ov = 1'b0;
                have    = 1'b0;
                continue;
            end
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1'b0, 32'(out_valid), 32'd0);
                end else begin
                    cur  = sb.pop_front();
                    have = 1'b1;
                    lat  = cur.dbz ? 0 : DW + EXTRA;
                    chk("result_edge_offset", (cyc - cur.acc) == lat, 32'(cyc - cur.acc), 32'(lat));
                    chk("quotient", quotient === cur.q, 32'(quotient), 32'(cur.q));
                    chk("remainder", remainder === cur.r, 32'(remainder), 32'(cur.r));
                    chk("div_by_zero", div_by_zero === cur.dbz, 32'(div_by_zero), 32'(cur.dbz));
                    chk("check_err", check_err === 1'b0, 32'(check_err), 32'd0);
                end
            end
            if (out_valid && out_ready && have) begin
                chk("held_result", {quotient, remainder, div_by_zero} === {cur.q, cur.r, cur.dbz},
                    32'({quotient, remainder}), 32'({cur.q, cur.r}));
                have = 1'b0;
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        int          k;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", in_ready === 1'b0, 32'(in_ready), 32'd0);
        chk("reset_outputs", {out_valid, quotient, remainder, div_by_zero, check_err} === '0,
            32'({quotient, remainder}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready === 1'b1, 32'(in_ready), 32'd1);

        // Directed operands
        rdy_auto = 1'b1;
        issue(16'hFE01, 8'hFF);
        issue(16'h03E8, 8'h07);
        issue(16'h0005, 8'h09);
        issue(16'hFFFF, 8'h01);
        issue(16'h1234, 8'h00);
        wait_drain(200);

        // Backpressure: result held while new operands wait on in_valid
        @(negedge clk);
        rdy_auto  = 1'b0;
        out_ready = 1'b0;
        issue(16'h03E8, 8'h07);
        wait_ov(40);
        dividend = 16'hFE01;
        divisor  = 8'hFF;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready === 1'b0, 32'(in_ready), 32'd0);
            chk("bp_held", {out_valid, quotient, remainder, div_by_zero} === {1'b1, 16'h008E, 8'h06, 1'b0},
                32'({quotient, remainder}), 32'h008E06);
        end
        out_ready = 1'b1;
        issue(16'hFE01, 8'hFF);
        rdy_auto = 1'b1;
        wait_drain(200);

        // Reset at BUSY iteration 7
        @(negedge clk);
        rdy_auto  = 1'b0;
        out_ready = 1'b1;
        chk("rst_test_ready", in_ready === 1'b1, 32'(in_ready), 32'd1);
        dividend = 16'hFE01;
        divisor  = 8'hFF;
        in_valid = 1'b1;
        k        = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (cyc < k + 7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready === 1'b0, 32'(in_ready), 32'd0);
        rst = 1'b0;
        chk("mid_rst_outputs", {out_valid, quotient, remainder, div_by_zero, check_err} === '0,
            32'({quotient, remainder}), 32'd0);
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) chk("mid_rst_no_result", 1'b0, 32'(out_valid), 32'd0);
        end
        chk("mid_rst_quiet", out_valid === 1'b0, 32'(out_valid), 32'd0);
        rdy_auto = 1'b1;
        issue(16'h03E8, 8'h07);
        wait_drain(200);

        // Randomised sweep
        for (int i = 0; i < 3000; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 300));
            b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            issue(a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain(400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
